// File: rtl/ahb_lite_uart_tx_streamer.sv
// ---------------------------------------------------------------------------
// ahb_lite_uart_tx_streamer
//
// AHB-Lite master placed directly in front of a UART16550 AHB-Lite slave.
// After reset it programs the UART in this order:
//   - line control with the divisor latch open
//   - divisor low byte, then divisor high byte
//   - line control again, now with the latch closed
//   - FIFO enable
//   - all interrupts off
// It then copies a valid/ready byte stream into the THR. It reads LSR.THRE
// before each burst, so the 16-byte TX FIFO can never be overrun. This is the
// console path used when no CPU master is present.
//
// Ports
//   HCLK, HRESETn         bus clock, asynchronous active-low reset
//   HADDR/HTRANS/HWRITE   address phase; only IDLE or NONSEQ is ever driven
//   HSIZE/HBURST/HPROT    constant word / SINGLE / data-privileged attributes
//   HMASTLOCK             constant 0
//   HWDATA                {24'b0, byte}, registered and held over the data phase
//   HRDATA/HREADY/HRESP   slave response; only HRDATA[7:0] is consumed
//   s_data/s_valid        byte stream input
//   s_ready               byte accepted on s_valid & s_ready at posedge
//   init_done             UART programming finished
//   err                   sticky bus-error flag, cleared only by reset
// ---------------------------------------------------------------------------
module ahb_lite_uart_tx_streamer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [15:0] DIVISOR   = 16'd27,
  parameter logic [7:0]  LCR_VAL   = 8'h03,
  parameter logic [4:0]  TX_DEPTH  = 5'd16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        init_done,
  output logic        err
);

  localparam logic [2:0] OFF_THR = 3'd0;
  localparam logic [2:0] OFF_LSR = 3'd5;

  // INIT0..INIT5 are encoded as 0..5, so the init step index is the state
  // value and "next init step" is simply state + 1.
  typedef enum logic [3:0] {
    S_INIT0     = 4'd0,
    S_INIT1     = 4'd1,
    S_INIT2     = 4'd2,
    S_INIT3     = 4'd3,
    S_INIT4     = 4'd4,
    S_INIT5     = 4'd5,
    S_INIT_WAIT = 4'd6,
    S_IDLE      = 4'd7,
    S_POLL      = 4'd8,
    S_SEND      = 4'd9
  } state_e;

  state_e      state_q, state_d;
  logic        live_q;        // low for the first cycle after reset: no bus activity during reset
  logic        dp_active_q, dp_active_d;
  logic        dp_read_q, dp_read_d;
  logic [4:0]  credit_q, credit_d;
  logic [7:0]  hwdata_q, hwdata_d;
  logic        init_done_q, init_done_d;
  logic        err_q, err_d;

  logic        issue_s;
  logic        issue_write_s;
  logic [2:0]  issue_off_s;
  logic [7:0]  issue_data_s;
  logic        s_ready_s;
  logic        dp_done_s;
  logic [2:0]  init_idx_s;
  logic        unused_s;

  // UART programming table: {register offset, data byte} for each init step.
  function automatic logic [10:0] init_step(input logic [2:0] idx);
    case (idx)
      3'd0:    init_step = {3'd3, 8'h80 | LCR_VAL};
      3'd1:    init_step = {3'd0, DIVISOR[7:0]};
      3'd2:    init_step = {3'd1, DIVISOR[15:8]};
      3'd3:    init_step = {3'd3, LCR_VAL};
      3'd4:    init_step = {3'd2, 8'h07};
      3'd5:    init_step = {3'd1, 8'h00};
      default: init_step = {3'd1, 8'h00};
    endcase
  endfunction

  assign init_idx_s = 3'(state_q);

  // State register and bus bookkeeping.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_INIT0;
      live_q      <= 1'b0;
      dp_active_q <= 1'b0;
      dp_read_q   <= 1'b0;
      credit_q    <= 5'd0;
      hwdata_q    <= 8'h00;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      dp_active_q <= dp_active_d;
      dp_read_q   <= dp_read_d;
      credit_q    <= credit_d;
      hwdata_q    <= hwdata_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic and address-phase generation.
  always_comb begin
    state_d       = state_q;
    dp_active_d   = dp_active_q;
    dp_read_d     = dp_read_q;
    credit_d      = credit_q;
    hwdata_d      = hwdata_q;
    init_done_d   = init_done_q;
    err_d         = err_q;
    issue_s       = 1'b0;
    issue_write_s = 1'b0;
    issue_off_s   = 3'd0;
    issue_data_s  = 8'h00;
    s_ready_s     = 1'b0;
    dp_done_s     = dp_active_q & HREADY;

    if (dp_done_s) begin
      dp_active_d = 1'b0;
    end else begin
      dp_active_d = dp_active_q;
    end

    // Both cycles of an ERROR response carry HRESP=1; either one is enough.
    if (dp_active_q & HRESP) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      S_INIT0, S_INIT1, S_INIT2, S_INIT3, S_INIT4, S_INIT5: begin
        {issue_off_s, issue_data_s} = init_step(init_idx_s);
        if (live_q && HREADY) begin
          issue_s       = 1'b1;
          issue_write_s = 1'b1;
          state_d       = state_e'(state_q + 4'd1);
        end else begin
          state_d = state_q;
        end
      end
      S_INIT_WAIT: begin
        if (dp_done_s) begin
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_INIT_WAIT;
        end
      end
      S_IDLE: begin
        if (s_valid && (credit_q == 5'd0)) begin
          state_d = S_POLL;
        end else if (s_valid) begin
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POLL: begin
        issue_off_s = OFF_LSR;
        if (HREADY) begin
          if (dp_active_q && dp_read_q && HRDATA[5]) begin
            credit_d = TX_DEPTH;
            state_d  = S_SEND;
          end else begin
            // Either no read is outstanding yet, or LSR said the FIFO is
            // still busy: issue the (next) LSR read back to back.
            issue_s = 1'b1;
          end
        end else begin
          state_d = S_POLL;
        end
      end
      S_SEND: begin
        issue_off_s  = OFF_THR;
        issue_data_s = s_data;
        s_ready_s    = HREADY & (credit_q != 5'd0);
        if (s_valid && s_ready_s) begin
          issue_s       = 1'b1;
          issue_write_s = 1'b1;
          credit_d      = credit_q - 5'd1;
        end else if (HREADY) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SEND;
        end
      end
      default: begin
        state_d = S_INIT0;
      end
    endcase

    if (issue_s) begin
      dp_active_d = 1'b1;
      dp_read_d   = ~issue_write_s;
      hwdata_d    = issue_write_s ? issue_data_s : 8'h00;
    end else begin
      hwdata_d = hwdata_q;
    end
  end

  assign HTRANS    = issue_s ? 2'b10 : 2'b00;
  assign HWRITE    = issue_s & issue_write_s;
  assign HADDR     = issue_s ? (BASE_ADDR + {27'd0, issue_off_s, 2'b00}) : BASE_ADDR;
  assign HWDATA    = {24'h00_0000, hwdata_q};
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign s_ready   = s_ready_s;
  assign init_done = init_done_q;
  assign err       = err_q;

  // Only LSR.THRE is of interest in read data.
  assign unused_s  = ^{HRDATA[31:6], HRDATA[4:0]};

endmodule

// File: tb/tb_ahb_lite_uart_tx_streamer.sv
module tb_ahb_lite_uart_tx_streamer;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        init_done;
  logic        err;

  ahb_lite_uart_tx_streamer dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .init_done(init_done), .err(err)
  );

  always #5 HCLK = ~HCLK;

  // UART slave model: every transfer has one wait state (2 cycles/transfer)
  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  data;
  } xfer_t;

  xfer_t       log_q[$];
  logic [7:0]  lsr_val;
  int          err_target = -1;
  int          thr_count;
  int          cyc = 0;
  logic        sl_busy;
  logic [31:0] sl_addr;
  logic        sl_wr;

  assign HRDATA = {24'h00_0000, lsr_val};

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HREADY  <= 1'b1;
      HRESP   <= 1'b0;
      sl_busy <= 1'b0;
      sl_addr <= 32'h0;
      sl_wr   <= 1'b0;
      thr_count <= 0;
    end else if (!HREADY) begin
      HREADY <= 1'b1;
    end else begin
      if (sl_busy) log_q.push_back({sl_addr, sl_wr, sl_wr ? HWDATA[7:0] : HRDATA[7:0]});
      HRESP   <= 1'b0;
      sl_busy <= 1'b0;
      if (HTRANS == 2'b10) begin
        sl_busy <= 1'b1;
        sl_addr <= HADDR;
        sl_wr   <= HWRITE;
        HREADY  <= 1'b0;
        if (HWRITE && HADDR == 32'h0) begin
          thr_count <= thr_count + 1;
          HRESP     <= (thr_count == err_target);
        end
      end
    end
  end

  // Reference model: expected THR byte order and number of THRE=1 polls,
  // derived from a credit counter that refills to 16 whenever it is empty.
  int          n_assert = 0;
  int          n_fail = 0;
  int          mark;
  int          model_credit = 0;
  int          exp_polls;
  logic [7:0]  exp_q[$];
  logic [7:0]  tx_q[$];
  int          hs_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_section();
    mark = log_q.size();
    exp_q.delete();
    exp_polls = 0;
  endtask

  task automatic plan(input logic [7:0] b);
    if (model_credit == 0) begin
      exp_polls++;
      model_credit = 16;
    end
    model_credit--;
    tx_q.push_back(b);
    exp_q.push_back(b);
  endtask

  function automatic int count_thr(input int from);
    int n = 0;
    for (int i = from; i < log_q.size(); i++)
      if (log_q[i].wr && log_q[i].addr == 32'h0) n++;
    return n;
  endfunction

  task automatic stream(input bit toggle);
    int  guard = 0;
    bit  v = 1'b1;
    while (tx_q.size() > 0 && guard < 3000) begin
      @(negedge HCLK);
      s_valid = v;
      s_data  = v ? tx_q[0] : 8'($urandom);
      #1;
      if (s_valid && s_ready) begin
        hs_cyc.push_back(cyc);
        void'(tx_q.pop_front());
      end
      if (toggle) v = ~v;
      guard++;
    end
    @(negedge HCLK);
    s_valid = 1'b0;
    s_data  = 8'($urandom);
    check("stream_left", tx_q.size(), 0);
  endtask

  task automatic wait_thr(input string tag, input int n);
    int g = 0;
    while (count_thr(mark) < n && g < 500) begin
      @(negedge HCLK);
      g++;
    end
    repeat (4) @(negedge HCLK);
    check({tag, "_thr_count"}, count_thr(mark), n);
  endtask

  task automatic check_since(input string tag);
    int nthr = 0;
    int npoll = 0;
    for (int i = mark; i < log_q.size(); i++) begin
      if (log_q[i].wr) begin
        check({tag, "_wr_addr"}, log_q[i].addr, 32'h0);
        if (nthr < exp_q.size()) check({tag, "_thr_data"}, log_q[i].data, exp_q[nthr]);
        nthr++;
      end else begin
        check({tag, "_rd_addr"}, log_q[i].addr, 32'h14);
        if (log_q[i].data[5]) npoll++;
      end
    end
    check({tag, "_polls"}, npoll, exp_polls);
  endtask

  task automatic wait_init(input string tag);
    logic [3:0]  offs [6];
    logic [7:0]  dats [6];
    bit          sr_any = 1'b0;
    int          g = 0;
    offs = '{4'hC, 4'h0, 4'h4, 4'hC, 4'h8, 4'h4};
    dats = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'h07, 8'h00};
    mark = log_q.size();
    while (!init_done && g < 200) begin
      @(negedge HCLK);
      #1;
      sr_any |= s_ready;
      g++;
    end
    check({tag, "_done"}, init_done, 1'b1);
    check({tag, "_sready_low"}, sr_any, 1'b0);
    check({tag, "_count"}, log_q.size() - mark, 6);
    if (log_q.size() >= mark + 6) begin
      for (int k = 0; k < 6; k++) begin
        check({tag, "_addr"}, log_q[mark + k].addr, {28'h0, offs[k]});
        check({tag, "_data"}, log_q[mark + k].data, dats[k]);
        check({tag, "_wr"}, log_q[mark + k].wr, 1'b1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sr_any;
    int g;
    int mn;
    int mx;
    HRESETn = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    lsr_val = 8'h60;

    // Reset values
    repeat (3) @(negedge HCLK);
    #1;
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_hwrite", HWRITE, 1'b0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_sready", s_ready, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_err", err, 1'b0);
    check("hsize", HSIZE, 3'b010);
    check("hburst", HBURST, 3'b000);
    check("hprot", HPROT, 4'b0011);
    check("hmastlock", HMASTLOCK, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // UART programming sequence
    wait_init("init1");

    // Single byte: one LSR read, then the THR write
    start_section();
    plan(8'h41);
    stream(1'b0);
    wait_thr("single", 1);
    check_since("single");
    if (log_q.size() > mark) check("single_first_is_lsr", {log_q[mark].wr, log_q[mark].addr}, {1'b0, 32'h14});

    // Use up the remaining credit so the next burst begins with a poll
    start_section();
    for (int i = 0; i < 15; i++) plan(8'($urandom));
    stream(1'b0);
    wait_thr("drain", 15);
    check_since("drain");

    // 16-byte burst at 2 cycles/byte, then a stalled poll, then 4 more
    start_section();
    hs_cyc.delete();
    for (int i = 0; i < 16; i++) plan(8'($urandom));
    stream(1'b0);
    lsr_val = 8'h00;
    check("burst_hs", hs_cyc.size(), 16);
    if (hs_cyc.size() == 16) begin
      mn = 1000;
      mx = 0;
      for (int i = 1; i < 16; i++) begin
        if (hs_cyc[i] - hs_cyc[i-1] < mn) mn = hs_cyc[i] - hs_cyc[i-1];
        if (hs_cyc[i] - hs_cyc[i-1] > mx) mx = hs_cyc[i] - hs_cyc[i-1];
      end
      check("burst_gap_min", mn, 2);
      check("burst_gap_max", mx, 2);
    end
    for (int i = 0; i < 4; i++) plan(8'($urandom));
    @(negedge HCLK);
    s_valid = 1'b1;
    s_data  = tx_q[0];
    sr_any  = 1'b0;
    repeat (40) begin
      @(negedge HCLK);
      #1;
      sr_any |= s_ready;
    end
    check("stall_sready", sr_any, 1'b0);
    check("stall_thr_count", count_thr(mark), 16);
    lsr_val = 8'h60;
    stream(1'b0);
    wait_thr("burst", 20);
    check_since("burst");

    // s_valid toggling every cycle, entered with zero credit
    start_section();
    for (int i = 0; i < 12; i++) plan(8'($urandom));
    stream(1'b0);
    for (int i = 0; i < 20; i++) plan(8'($urandom));
    stream(1'b1);
    wait_thr("toggle", 32);
    check_since("toggle");

    // Error response on a THR write: sticky err, stream continues
    check("err_before", err, 1'b0);
    start_section();
    err_target = thr_count + 1;
    for (int i = 0; i < 5; i++) plan(8'($urandom));
    stream(1'b0);
    wait_thr("errburst", 5);
    check("err_set", err, 1'b1);
    check_since("errburst");
    start_section();
    for (int i = 0; i < 3; i++) plan(8'($urandom));
    stream(1'b0);
    wait_thr("after_err", 3);
    check_since("after_err");
    check("err_sticky", err, 1'b1);

    // Asynchronous reset in the middle of a THR data phase
    @(negedge HCLK);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    g = 0;
    #1;
    while (!s_ready && g < 100) begin
      @(negedge HCLK);
      #1;
      g++;
    end
    check("pre_reset_ready", s_ready, 1'b1);
    @(posedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    check("arst_htrans", HTRANS, 2'b00);
    check("arst_init_done", init_done, 1'b0);
    check("arst_err", err, 1'b0);
    check("arst_sready", s_ready, 1'b0);
    s_valid = 1'b0;
    model_credit = 0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    wait_init("init2");
    start_section();
    for (int i = 0; i < 3; i++) plan(8'($urandom));
    stream(1'b0);
    wait_thr("post_reset", 3);
    check_since("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
